// File: rtl/decode_stage.sv
// Instruction-decode pipeline stage: decodes one instruction per cycle into
// datapath controls, tracks pending register writes to stall on RAW/WAW
// hazards, honours branch flush and parks in HALTED after a HALT retires.
module decode_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    localparam int INST_W = 4 + 3*REG_AW + 3,
    localparam int IMM_W  = REG_AW + 3,
    localparam int NREG   = 2**REG_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] dr,
    output logic [REG_AW-1:0] sa,
    output logic [REG_AW-1:0] sb,
    output logic [2:0]        fs,
    output logic [2:0]        bs,
    output logic              mb,
    output logic              md,
    output logic              ld,
    output logic              mw,
    output logic [DATA_W-1:0] imm_x,
    output logic [DATA_W-1:0] off_x,
    output logic              halt,
    output logic              illegal,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic              flush,
    input  logic              resume,
    output logic              halted
);

    localparam logic [2:0] FS_ADD  = 3'd0;
    localparam logic [2:0] FS_SUB  = 3'd1;
    localparam logic [2:0] FS_AND  = 3'd5;
    localparam logic [2:0] FS_OR   = 3'd6;
    localparam logic [2:0] BS_EQ   = 3'd0;
    localparam logic [2:0] BS_NE   = 3'd1;
    localparam logic [2:0] BS_GEZ  = 3'd2;
    localparam logic [2:0] BS_LTZ  = 3'd3;
    localparam logic [2:0] BS_NONE = 3'd4;

    typedef enum logic {ST_RUN, ST_HALTED} state_t;

    function automatic logic signed [DATA_W-1:0] sext_imm(input logic [IMM_W-1:0] f);
        return {{(DATA_W-IMM_W){f[IMM_W-1]}}, f};
    endfunction

    // ---- stage 0: raw instruction fields and combinational decode ----
    logic [3:0]        op_p0;
    logic [REG_AW-1:0] rs_p0, rt_p0, rd_p0;
    logic [2:0]        funct_p0;
    logic [IMM_W-1:0]  imm_p0;

    assign op_p0    = inst[INST_W-1 -: 4];
    assign rs_p0    = inst[3*REG_AW+2 -: REG_AW];
    assign rt_p0    = inst[2*REG_AW+2 -: REG_AW];
    assign rd_p0    = inst[REG_AW+2 -: REG_AW];
    assign funct_p0 = inst[2:0];
    assign imm_p0   = inst[IMM_W-1:0];

    logic [REG_AW-1:0]        dr_p0, sa_p0, sb_p0;
    logic [2:0]               fs_p0, bs_p0;
    logic                     mb_p0, md_p0, ld_p0, mw_p0, halt_p0, illegal_p0;
    logic signed [DATA_W-1:0] imm_x_p0, off_x_p0;

    // Opcode decode into the control bundle; unused fields stay zero.
    always_comb begin
        dr_p0      = '0;
        sa_p0      = '0;
        sb_p0      = '0;
        fs_p0      = FS_ADD;
        bs_p0      = BS_NONE;
        mb_p0      = 1'b0;
        md_p0      = 1'b0;
        ld_p0      = 1'b0;
        mw_p0      = 1'b0;
        imm_x_p0   = '0;
        off_x_p0   = '0;
        halt_p0    = 1'b0;
        illegal_p0 = 1'b0;
        case (op_p0)
            4'd0: begin
                bs_p0   = BS_EQ;
                halt_p0 = (funct_p0 != 3'd0);
            end
            4'd2: begin
                dr_p0 = rt_p0; sa_p0 = rs_p0; mb_p0 = 1'b1;
                md_p0 = 1'b1;  ld_p0 = 1'b1;  imm_x_p0 = sext_imm(imm_p0);
            end
            4'd4: begin
                sa_p0 = rs_p0; sb_p0 = rt_p0; mb_p0 = 1'b1;
                mw_p0 = 1'b1;  imm_x_p0 = sext_imm(imm_p0);
            end
            4'd5, 4'd6, 4'd7: begin
                dr_p0 = rt_p0; sa_p0 = rs_p0; mb_p0 = 1'b1; ld_p0 = 1'b1;
                imm_x_p0 = sext_imm(imm_p0);
                fs_p0 = (op_p0 == 4'd5) ? FS_ADD : (op_p0 == 4'd6) ? FS_AND : FS_OR;
            end
            4'd8, 4'd9: begin
                sa_p0 = rs_p0; sb_p0 = rt_p0; fs_p0 = FS_SUB;
                bs_p0 = (op_p0 == 4'd8) ? BS_EQ : BS_NE;
                off_x_p0 = sext_imm(imm_p0);
            end
            4'd10, 4'd11: begin
                // Compare against zero: B-mux selects the (zero) immediate.
                sa_p0 = rs_p0; mb_p0 = 1'b1;
                bs_p0 = (op_p0 == 4'd10) ? BS_GEZ : BS_LTZ;
                off_x_p0 = sext_imm(imm_p0);
            end
            4'd15: begin
                if (funct_p0 == 3'd7) begin
                    illegal_p0 = 1'b1;
                end else begin
                    dr_p0 = rd_p0; sa_p0 = rs_p0; sb_p0 = rt_p0;
                    ld_p0 = 1'b1;  fs_p0 = funct_p0;
                end
            end
            default: illegal_p0 = 1'b1;
        endcase
    end

    // ---- stage 1: output register state ----
    logic                     vld_p1;
    logic [REG_AW-1:0]        dr_p1, sa_p1, sb_p1;
    logic [2:0]               fs_p1, bs_p1;
    logic                     mb_p1, md_p1, ld_p1, mw_p1, halt_p1, illegal_p1;
    logic signed [DATA_W-1:0] imm_x_p1, off_x_p1;

    logic [NREG-1:0] pend_q, pend_d, pend_vec, pend_set, pend_clr;
    state_t          state_q, state_d;
    logic            hazard, xfer_in, xfer_out;

    // A register is pending if the scoreboard holds it or the held bundle will write it.
    always_comb begin
        pend_vec = pend_q;
        if (vld_p1 && ld_p1) pend_vec[dr_p1] = 1'b1;
        pend_vec[0] = 1'b0;
    end

    assign hazard = pend_vec[sa_p0]
                  | ((!mb_p0 || mw_p0) && pend_vec[sb_p0])
                  | (ld_p0 && pend_vec[dr_p0]);

    assign in_ready = (state_q == ST_RUN) && !hazard && !flush && (!vld_p1 || out_ready);
    assign xfer_in  = in_valid && in_ready;
    assign xfer_out = vld_p1 && out_ready && !flush;

    // Scoreboard next state: retire clears, issue sets, set wins on collision.
    always_comb begin
        pend_set = '0;
        pend_clr = '0;
        if (xfer_out && ld_p1) pend_set[dr_p1]   = 1'b1;
        if (wb_en)             pend_clr[wb_addr] = 1'b1;
        pend_d    = (pend_q & ~pend_clr) | pend_set;
        pend_d[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    // HALT FSM next state: enter on a retired HALT, leave on RESUME.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (xfer_out && halt_p1) state_d = ST_HALTED;
            ST_HALTED: if (resume)              state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    // HALT FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    // Output register: load on accept, drop on flush or hand-off, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            dr_p1      <= '0;
            sa_p1      <= '0;
            sb_p1      <= '0;
            fs_p1      <= FS_ADD;
            bs_p1      <= BS_NONE;
            mb_p1      <= 1'b0;
            md_p1      <= 1'b0;
            ld_p1      <= 1'b0;
            mw_p1      <= 1'b0;
            imm_x_p1   <= '0;
            off_x_p1   <= '0;
            halt_p1    <= 1'b0;
            illegal_p1 <= 1'b0;
        end else if (xfer_in) begin
            vld_p1     <= 1'b1;
            dr_p1      <= dr_p0;
            sa_p1      <= sa_p0;
            sb_p1      <= sb_p0;
            fs_p1      <= fs_p0;
            bs_p1      <= bs_p0;
            mb_p1      <= mb_p0;
            md_p1      <= md_p0;
            ld_p1      <= ld_p0;
            mw_p1      <= mw_p0;
            imm_x_p1   <= imm_x_p0;
            off_x_p1   <= off_x_p0;
            halt_p1    <= halt_p0;
            illegal_p1 <= illegal_p0;
        end else if (flush || (vld_p1 && out_ready)) begin
            vld_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign dr        = dr_p1;
    assign sa        = sa_p1;
    assign sb        = sb_p1;
    assign fs        = fs_p1;
    assign bs        = bs_p1;
    assign mb        = mb_p1;
    assign md        = md_p1;
    assign ld        = ld_p1;
    assign mw        = mw_p1;
    assign imm_x     = imm_x_p1;
    assign off_x     = off_x_p1;
    assign halt      = halt_p1;
    assign illegal   = illegal_p1;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: default 16-bit build plus a 32-bit/REG_AW=4 build.
module tb_decode_stage;

    logic        clk;
    logic        rst_n;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] inst;
    logic [2:0]  dr, sa, sb, fs, bs, wb_addr;
    logic        mb, md, ld, mw, halt, illegal, wb_en, flush, resume, halted;
    logic [15:0] imm_x, off_x;

    logic        w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [18:0] w_inst;
    logic [3:0]  w_dr, w_sa, w_sb, w_wb_addr;
    logic [2:0]  w_fs, w_bs;
    logic        w_mb, w_md, w_ld, w_mw, w_halt, w_illegal, w_wb_en, w_flush, w_resume, w_halted;
    logic [31:0] w_imm_x, w_off_x;

    int n_checks = 0;
    int n_errors = 0;

    decode_stage u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
        .out_valid(out_valid), .out_ready(out_ready), .dr(dr), .sa(sa), .sb(sb),
        .fs(fs), .bs(bs), .mb(mb), .md(md), .ld(ld), .mw(mw), .imm_x(imm_x), .off_x(off_x),
        .halt(halt), .illegal(illegal), .wb_en(wb_en), .wb_addr(wb_addr), .flush(flush),
        .resume(resume), .halted(halted)
    );

    decode_stage #(.DATA_W(32), .REG_AW(4)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready), .inst(w_inst),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .dr(w_dr), .sa(w_sa), .sb(w_sb),
        .fs(w_fs), .bs(w_bs), .mb(w_mb), .md(w_md), .ld(w_ld), .mw(w_mw), .imm_x(w_imm_x),
        .off_x(w_off_x), .halt(w_halt), .illegal(w_illegal), .wb_en(w_wb_en),
        .wb_addr(w_wb_addr), .flush(w_flush), .resume(w_resume), .halted(w_halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; inst = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; flush = 1'b0; resume = 1'b0;
        w_in_valid = 1'b0; w_inst = '0; w_out_ready = 1'b1; w_wb_en = 1'b0;
        w_wb_addr = '0; w_flush = 1'b0; w_resume = 1'b0;
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_bs", bs, 4);
        check("rst_halted", halted, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_imm_x", imm_x, 0);

        // wide build: BLTZ with offset field 7'h40
        w_inst = 19'h58040; w_in_valid = 1'b1;
        #1 check("w_in_ready", w_in_ready, 1);
        step(); w_in_valid = 1'b0; #1;
        check("w_out_valid", w_out_valid, 1);
        check("w_off_x", w_off_x, 32'hFFFFFFC0);
        check("w_bs", w_bs, 3);
        check("w_mb", w_mb, 1);
        check("w_imm_x", w_imm_x, 0);
        check("w_sb", w_sb, 0);
        check("w_ld", w_ld, 0);
        check("w_mw_md", {w_mw, w_md, w_halt, w_illegal, w_halted}, 0);
        check("w_dr_sa_fs", {w_dr, w_sa, w_fs}, 0);

        // ADDI r1,r0,-3
        out_ready = 1'b0; inst = 16'h507D; in_valid = 1'b1;
        #1 check("addi_in_ready", in_ready, 1);
        step(); in_valid = 1'b0; inst = '0; #1;
        check("addi_valid", out_valid, 1);
        check("addi_dr", dr, 1);
        check("addi_sa", sa, 0);
        check("addi_mb", mb, 1);
        check("addi_ld", ld, 1);
        check("addi_fs", fs, 0);
        check("addi_imm_x", imm_x, 16'hFFFD);
        check("addi_bs", bs, 4);

        // backpressure for 5 cycles
        in_valid = 1'b1; inst = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_ready", in_ready, 0);
            check("bp_valid", out_valid, 1);
            check("bp_imm_x", imm_x, 16'hFFFD);
            check("bp_dr", dr, 1);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        step();
        check("bp_xfer_once", out_valid, 0);

        // RAW: ADD r2=r1+r1 waits for writeback of r1
        inst = 16'hF250; in_valid = 1'b1;
        #1 check("raw_stall0", in_ready, 0);
        step();
        check("raw_stall1", in_ready, 0);
        wb_en = 1'b1; wb_addr = 3'd1;
        #1 check("raw_no_bypass", in_ready, 0);
        step(); wb_en = 1'b0;
        #1 check("raw_released", in_ready, 1);
        step(); in_valid = 1'b0; #1;
        check("add_valid", out_valid, 1);
        check("add_dr", dr, 2);
        check("add_sa", sa, 1);
        check("add_sb", sb, 1);
        check("add_ld", ld, 1);
        check("add_mb", mb, 0);

        // set wins over clear of the same register in one cycle
        wb_en = 1'b1; wb_addr = 3'd2;
        step(); wb_en = 1'b0;
        inst = 16'h54C1; in_valid = 1'b1;
        #1 check("set_wins", in_ready, 0);
        check("set_wins_vld", out_valid, 0);
        in_valid = 1'b0; wb_en = 1'b1; wb_addr = 3'd2;
        step(); wb_en = 1'b0; in_valid = 1'b1;
        #1 check("clr_r2", in_ready, 1);
        in_valid = 1'b0;

        // illegal opcodes flow downstream
        inst = 16'h1000; in_valid = 1'b1;
        #1 step(); inst = 16'hF007;
        #1;
        check("ill_op1", illegal, 1);
        check("ill_op1_bs", bs, 4);
        check("ill_op1_ld", ld, 0);
        check("ill_op1_vld", out_valid, 1);
        check("ill_next_ready", in_ready, 1);
        step(); in_valid = 1'b0; #1;
        check("ill_r7", illegal, 1);
        check("ill_r7_ld", ld, 0);
        step();

        // BEQ flushed while a HALT waits at the input
        inst = 16'h8005; in_valid = 1'b1;
        #1 step(); in_valid = 1'b0; #1;
        check("beq_bs", bs, 0);
        check("beq_off_x", off_x, 16'h0005);
        check("beq_imm_x", imm_x, 0);
        check("beq_fs", fs, 1);
        check("beq_valid", out_valid, 1);
        flush = 1'b1; inst = 16'h0001; in_valid = 1'b1;
        #1 check("flush_in_ready", in_ready, 0);
        step(); flush = 1'b0; in_valid = 1'b0; #1;
        check("flush_valid", out_valid, 0);
        check("flush_halted", halted, 0);
        step();
        check("flush_no_accept", out_valid, 0);

        // HALT transfers, then RESUME
        inst = 16'h0001; in_valid = 1'b1; out_ready = 1'b0;
        #1 step(); in_valid = 1'b0; #1;
        check("halt_flag", halt, 1);
        check("halt_bs", bs, 0);
        check("halt_valid", out_valid, 1);
        check("halt_not_yet", halted, 0);
        out_ready = 1'b1;
        step();
        check("halted_set", halted, 1);
        check("halted_vld", out_valid, 0);
        inst = 16'h0000; in_valid = 1'b1;
        #1 check("halted_in_ready", in_ready, 0);
        step(); step();
        check("halted_hold", halted, 1);
        resume = 1'b1;
        #1 check("resume_pre_edge", halted, 1);
        step(); resume = 1'b0; #1;
        check("resumed", halted, 0);
        check("resumed_ready", in_ready, 1);
        in_valid = 1'b0;

        // reset mid-stream with a bundle held and r1 pending
        inst = 16'h507D; in_valid = 1'b1; out_ready = 1'b1;
        #1 step(); in_valid = 1'b0;
        step();
        inst = 16'h50BD; in_valid = 1'b1; out_ready = 1'b0;
        #1 check("pre_rst_ready", in_ready, 1);
        step(); in_valid = 1'b0; #1;
        check("pre_rst_valid", out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_bs", bs, 4);
        check("mid_rst_halted", halted, 0);
        check("mid_rst_ld", ld, 0);
        step(); rst_n = 1'b1; out_ready = 1'b1;
        #1 check("post_rst_ready", in_ready, 1);
        inst = 16'hF250; in_valid = 1'b1;
        #1 check("rst_sb_clear", in_ready, 1);
        in_valid = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
